// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end: a PC generator feeding a DEPTH-entry prefetch
// FIFO of {PC+4, instr} pairs. The PC drives instruction memory directly, the
// returned instruction is captured in the same cycle, and decode drains the
// queue through a valid/ready handshake. A redirect flushes the queue and
// reloads the PC in a single cycle.
//
// Parameters:
//   DATA_W    instruction width
//   ADDR_W    PC / address width
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  PC loaded on reset
//
// Ports:
//   clk_i          clock, all state updates on rising edge
//   rst_i          synchronous active-high reset
//   start_i        fetch enable (level)
//   fetch_pc_o     instruction memory address (the PC register)
//   imem_instr_i   instruction for fetch_pc_o, returned in the same cycle
//   redirect_i     branch/jump taken: flush queue, reload PC
//   redirect_pc_i  redirect target; low two bits forced to zero
//   pop_valid_o    head entry available to decode
//   pop_ready_i    decode accepts head (low = stall)
//   pop_instr_o    head instruction
//   pop_pc4_o      head PC+4
//   count_o        current occupancy
//   full_o         count_o == DEPTH
//   empty_o        count_o == 0
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    output logic [ADDR_W-1:0]          fetch_pc_o,
    input  logic [DATA_W-1:0]          imem_instr_i,
    input  logic                       redirect_i,
    input  logic [ADDR_W-1:0]          redirect_pc_i,
    output logic                       pop_valid_o,
    input  logic                       pop_ready_i,
    output logic [DATA_W-1:0]          pop_instr_o,
    output logic [ADDR_W-1:0]          pop_pc4_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Storage has no reset; only pointers and count define validity.
    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc4_mem_q   [DEPTH];

    // ---------------------------------------------------------------------
    // Handshake decode
    // ---------------------------------------------------------------------
    logic              is_full;
    logic              is_empty;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] pc_plus4;

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);
    assign pc_plus4 = pc_q + ADDR_W'(4);

    // Redirect masks the head combinationally so decode can never accept a
    // wrong-path instruction in the cycle the branch resolves.
    assign pop_valid_o = !is_empty && !redirect_i;
    assign pop         = pop_valid_o && pop_ready_i;

    // A full queue may still accept a fetch when the head leaves this cycle.
    assign push = start_i && !redirect_i && (!is_full || pop);

    // ---------------------------------------------------------------------
    // Next state
    // ---------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (redirect_i) begin
            pc_d     = {redirect_pc_i[ADDR_W-1:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_plus4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Gated by reset so a reset cycle never disturbs the storage either.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            instr_mem_q[wr_ptr_q] <= imem_instr_i;
            pc4_mem_q[wr_ptr_q]   <= pc_plus4;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs (register-derived except pop_valid_o)
    // ---------------------------------------------------------------------
    assign fetch_pc_o  = pc_q;
    assign pop_instr_o = instr_mem_q[rd_ptr_q];
    assign pop_pc4_o   = pc4_mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign full_o      = is_full;
    assign empty_o     = is_empty;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Two instances: A (defaults, DEPTH=4, 32-bit PC, RESET_PC=0) and B (DEPTH=2,
// 8-bit PC, RESET_PC=0xFC) for PC wrap-around. The stimulus process pushes
// hand-computed {instr, pc4} entries into per-instance expected queues; a
// monitor per instance pops and compares whenever decode accepts the head.
// Occupancy, PC and flags are checked directly after each edge.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- Instance A ----------------
    logic        rst_a, start_a, redir_a, ready_a;
    logic [31:0] redir_pc_a;
    logic [31:0] pc_a, imem_a, instr_a, pc4_a;
    logic        valid_a, full_a, empty_a;
    logic [2:0]  count_a;

    assign imem_a = pc_a | 32'hA000_0000;

    fetch_queue #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .DEPTH   (4),
        .RESET_PC(32'h0)
    ) dut_a (
        .clk_i        (clk),
        .rst_i        (rst_a),
        .start_i      (start_a),
        .fetch_pc_o   (pc_a),
        .imem_instr_i (imem_a),
        .redirect_i   (redir_a),
        .redirect_pc_i(redir_pc_a),
        .pop_valid_o  (valid_a),
        .pop_ready_i  (ready_a),
        .pop_instr_o  (instr_a),
        .pop_pc4_o    (pc4_a),
        .count_o      (count_a),
        .full_o       (full_a),
        .empty_o      (empty_a)
    );

    // ---------------- Instance B ----------------
    logic        rst_b, start_b, redir_b, ready_b;
    logic [7:0]  redir_pc_b, pc_b, pc4_b;
    logic [31:0] imem_b, instr_b;
    logic        valid_b, full_b, empty_b;
    logic [1:0]  count_b;

    assign imem_b = {24'hA0_0000, pc_b};

    fetch_queue #(
        .DATA_W  (32),
        .ADDR_W  (8),
        .DEPTH   (2),
        .RESET_PC(8'hFC)
    ) dut_b (
        .clk_i        (clk),
        .rst_i        (rst_b),
        .start_i      (start_b),
        .fetch_pc_o   (pc_b),
        .imem_instr_i (imem_b),
        .redirect_i   (redir_b),
        .redirect_pc_i(redir_pc_b),
        .pop_valid_o  (valid_b),
        .pop_ready_i  (ready_b),
        .pop_instr_o  (instr_b),
        .pop_pc4_o    (pc4_b),
        .count_o      (count_b),
        .full_o       (full_b),
        .empty_o      (empty_b)
    );

    // ---------------- Scoreboard ----------------
    logic [63:0] exp_a[$];  // {instr, pc4}
    logic [39:0] exp_b[$];  // {instr, pc4}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_a && valid_a && ready_a) begin
            if (exp_a.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL a_pop_unexpected: got instr %0h pc4 %0h, expected no pop",
                         instr_a, pc4_a);
            end else begin
                logic [63:0] e;
                e = exp_a.pop_front();
                chk("a_pop_instr", 64'(instr_a), 64'(e[63:32]));
                chk("a_pop_pc4", 64'(pc4_a), 64'(e[31:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && valid_b && ready_b) begin
            if (exp_b.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL b_pop_unexpected: got instr %0h pc4 %0h, expected no pop",
                         instr_b, pc4_b);
            end else begin
                logic [39:0] e;
                e = exp_b.pop_front();
                chk("b_pop_instr", 64'(instr_b), 64'(e[39:8]));
                chk("b_pop_pc4", 64'(pc4_b), 64'(e[7:0]));
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a   = 1'b1;
        start_a = 1'b0;
        ready_a = 1'b0;
        redir_a = 1'b0;
        tick();
        rst_a = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1; start_a = 1'b0; redir_a = 1'b0; ready_a = 1'b0; redir_pc_a = '0;
        rst_b = 1'b1; start_b = 1'b0; redir_b = 1'b0; ready_b = 1'b0; redir_pc_b = '0;
        tick();
        tick();
        rst_a = 1'b0;

        // Reset state
        chk("rst_count", 64'(count_a), 64'd0);
        chk("rst_empty", 64'(empty_a), 64'd1);
        chk("rst_full", 64'(full_a), 64'd0);
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_pc", 64'(pc_a), 64'h0);

        // Streaming: one entry in flight, popped every cycle
        exp_a.push_back({32'hA000_0000, 32'h4});
        exp_a.push_back({32'hA000_0004, 32'h8});
        exp_a.push_back({32'hA000_0008, 32'hC});
        start_a = 1'b1;
        ready_a = 1'b1;
        tick();
        chk("str_count1", 64'(count_a), 64'd1);
        chk("str_valid1", 64'(valid_a), 64'd1);
        chk("str_head1", 64'(instr_a), 64'hA000_0000);
        chk("str_pc1", 64'(pc_a), 64'h4);
        tick();
        chk("str_count2", 64'(count_a), 64'd1);
        chk("str_pc2", 64'(pc_a), 64'h8);
        tick();
        chk("str_count3", 64'(count_a), 64'd1);
        chk("str_pc3", 64'(pc_a), 64'hC);
        start_a = 1'b0;
        tick();
        chk("str_empty", 64'(empty_a), 64'd1);
        chk("str_pc_hold", 64'(pc_a), 64'hC);

        // Fill to full under stall, then push+pop while full
        reset_a();
        start_a = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            int n;
            n = (i < 4) ? i : 4;
            tick();
            chk("fill_count", 64'(count_a), 64'(n));
            chk("fill_pc", 64'(pc_a), 64'(n * 4));
            chk("fill_full", 64'(full_a), 64'(i >= 4));
        end
        chk("fill_head_instr", 64'(instr_a), 64'hA000_0000);
        chk("fill_head_pc4", 64'(pc4_a), 64'h4);
        chk("fill_valid", 64'(valid_a), 64'd1);
        exp_a.push_back({32'hA000_0000, 32'h4});
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        chk("fullpp_count", 64'(count_a), 64'd4);
        chk("fullpp_pc", 64'(pc_a), 64'h14);
        chk("fullpp_head", 64'(pc4_a), 64'h8);

        // Redirect with 3 queued entries
        reset_a();
        start_a = 1'b1;
        tick();
        tick();
        tick();
        chk("redir_pre_count", 64'(count_a), 64'd3);
        redir_a    = 1'b1;
        redir_pc_a = 32'h43;
        ready_a    = 1'b1;
        #1;
        chk("redir_valid_mask", 64'(valid_a), 64'd0);
        tick();
        redir_a = 1'b0;
        chk("redir_count", 64'(count_a), 64'd0);
        chk("redir_pc", 64'(pc_a), 64'h40);
        exp_a.push_back({32'hA000_0040, 32'h44});
        tick();
        start_a = 1'b0;
        chk("redir_head_pc4", 64'(pc4_a), 64'h44);
        chk("redir_count2", 64'(count_a), 64'd1);
        tick();
        chk("redir_drained", 64'(empty_a), 64'd1);
        chk("redir_pc_hold", 64'(pc_a), 64'h44);
        ready_a = 1'b0;

        // Reset beats a simultaneous redirect
        reset_a();
        start_a = 1'b1;
        tick();
        tick();
        chk("rr_pre_count", 64'(count_a), 64'd2);
        rst_a      = 1'b1;
        redir_a    = 1'b1;
        redir_pc_a = 32'h80;
        ready_a    = 1'b1;
        tick();
        rst_a   = 1'b0;
        redir_a = 1'b0;
        start_a = 1'b0;
        ready_a = 1'b0;
        chk("rr_count", 64'(count_a), 64'd0);
        chk("rr_pc", 64'(pc_a), 64'h0);
        chk("rr_empty", 64'(empty_a), 64'd1);

        // Drain with fetching disabled
        start_a = 1'b1;
        tick();
        tick();
        chk("drain_pre_count", 64'(count_a), 64'd2);
        start_a = 1'b0;
        ready_a = 1'b1;
        exp_a.push_back({32'hA000_0000, 32'h4});
        exp_a.push_back({32'hA000_0004, 32'h8});
        tick();
        chk("drain_count1", 64'(count_a), 64'd1);
        chk("drain_pc1", 64'(pc_a), 64'h8);
        tick();
        chk("drain_empty", 64'(empty_a), 64'd1);
        chk("drain_pc2", 64'(pc_a), 64'h8);
        ready_a = 1'b0;

        // Instance B: PC wrap at 8 bits, DEPTH=2
        rst_b = 1'b0;
        chk("b_rst_pc", 64'(pc_b), 64'hFC);
        chk("b_rst_empty", 64'(empty_b), 64'd1);
        start_b = 1'b1;
        tick();
        chk("b_count1", 64'(count_b), 64'd1);
        chk("b_head_pc4", 64'(pc4_b), 64'h00);
        chk("b_head_instr", 64'(instr_b), 64'hA000_00FC);
        chk("b_pc_wrap", 64'(pc_b), 64'h00);
        tick();
        chk("b_full", 64'(full_b), 64'd1);
        chk("b_pc2", 64'(pc_b), 64'h04);
        tick();
        chk("b_count_hold", 64'(count_b), 64'd2);
        chk("b_pc_hold", 64'(pc_b), 64'h04);
        start_b = 1'b0;
        ready_b = 1'b1;
        exp_b.push_back({32'hA000_00FC, 8'h00});
        exp_b.push_back({32'hA000_0000, 8'h04});
        tick();
        chk("b_drain1", 64'(count_b), 64'd1);
        tick();
        chk("b_drain_empty", 64'(empty_b), 64'd1);
        ready_b = 1'b0;

        tick();
        chk("a_scoreboard_left", 64'(exp_a.size()), 64'd0);
        chk("b_scoreboard_left", 64'(exp_b.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
